// File: rtl/rvh_l1d_pkg.sv
// rtl/rvh_l1d_pkg.sv - load-response field widths and packed metadata/refill types.
package rvh_l1d_pkg;

    localparam int LD_REQ_TYPE_DEC_WIDTH   = 14;
    localparam int ROB_TAG_WIDTH           = 4;
    localparam int PREG_TAG_WIDTH          = 4;
    localparam int RRV64_LSU_ID_WIDTH      = 12;
    localparam int L1D_BANK_OFFSET_WIDTH   = 6;
    localparam int L1D_BANK_LINE_DATA_SIZE = 512;

    typedef struct packed {
        logic [LD_REQ_TYPE_DEC_WIDTH-1:0] req_type_dec;
        logic [ROB_TAG_WIDTH-1:0]         rob_tag;
        logic [PREG_TAG_WIDTH-1:0]        prd;
        logic [RRV64_LSU_ID_WIDTH-1:0]    lsu_tag;
        logic [L1D_BANK_OFFSET_WIDTH-1:0] offset;
    } ld_resp_meta_t;

    localparam int LD_RESP_META_WIDTH = $bits(ld_resp_meta_t);

    typedef struct packed {
        ld_resp_meta_t                      meta;
        logic [L1D_BANK_LINE_DATA_SIZE-1:0] line;
    } refill_entry_t;

endpackage

// File: rtl/rvh_l1d_resp_refill_fifo.sv
// rtl/rvh_l1d_resp_refill_fifo.sv - refill replay queue; ready reflects the post-pop occupancy.
module rvh_l1d_resp_refill_fifo
    import rvh_l1d_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld,
    input  refill_entry_t push_data,
    output logic          push_rdy,
    input  logic          pop,
    output logic          head_vld,
    output refill_entry_t head_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    refill_entry_t    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A slot freed by this cycle's pop may be refilled in the same cycle.
    assign push_rdy  = (count != CNT_W'(DEPTH)) || pop;
    assign do_push   = push_vld && push_rdy;
    assign head_vld  = (count != '0);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rvh_l1d_ld_resp_sched.sv
// rtl/rvh_l1d_ld_resp_sched.sv - arbitrates load-pipe hits against queued refills onto the response path.
// Define RVH_L1D_RESP_STARVE_GUARD_EN to enable the refill starvation guard (pipe stall request).
module rvh_l1d_ld_resp_sched
    import rvh_l1d_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int RQ_DEPTH   = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               pipe_vld_i,
    input  logic [LD_RESP_META_WIDTH-1:0]      pipe_meta_i,
    input  logic                               refill_vld_i,
    output logic                               refill_rdy_o,
    input  logic [LD_RESP_META_WIDTH-1:0]      refill_meta_i,
    input  logic [L1D_BANK_LINE_DATA_SIZE-1:0] refill_line_i,
    output logic                               pipe_stall_o,
    output logic                               resp_valid_o,
    output logic                               refill_valid_o,
    output logic [LD_RESP_META_WIDTH-1:0]      resp_meta_o,
    output logic [L1D_BANK_LINE_DATA_SIZE-1:0] resp_line_o
);

    refill_entry_t push_data;
    refill_entry_t head_data;
    logic          head_vld;
    logic          pipe_win;
    logic          head_win;

    assign push_data.meta = ld_resp_meta_t'(refill_meta_i);
    assign push_data.line = refill_line_i;

    rvh_l1d_resp_refill_fifo #(
        .DEPTH (RQ_DEPTH)
    ) u_refill_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_vld  (refill_vld_i),
        .push_data (push_data),
        .push_rdy  (refill_rdy_o),
        .pop       (head_win),
        .head_vld  (head_vld),
        .head_data (head_data)
    );

    // The pipe cannot be backpressured, so it always wins when present.
    assign pipe_win = pipe_vld_i;
    assign head_win = !pipe_vld_i && head_vld;

`ifdef RVH_L1D_RESP_STARVE_GUARD_EN
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    logic [SW-1:0] starve_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (head_win || !head_vld) begin
            starve_cnt <= '0;
        end else if (pipe_win && (starve_cnt != SW'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign pipe_stall_o = (starve_cnt == SW'(STARVE_MAX)) && head_vld;
`else
    assign pipe_stall_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid_o   <= 1'b0;
            refill_valid_o <= 1'b0;
            resp_meta_o    <= '0;
            resp_line_o    <= '0;
        end else begin
            resp_valid_o   <= pipe_win || head_win;
            refill_valid_o <= head_win;
            if (pipe_win) begin
                resp_meta_o <= pipe_meta_i;
            end else if (head_win) begin
                resp_meta_o <= head_data.meta;
            end
            // The line only carries refill data; pipe hits leave it untouched.
            if (head_win) resp_line_o <= head_data.line;
        end
    end

endmodule
